decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised instruction-decode stage with a built-in output queue. It accepts raw 32-bit RV32I instruction words plus their PC over a valid/ready handshake and decodes every field in one cycle, including a fully sign-extended immediate for all six formats. It stores the decoded records in a DEPTH-entry FIFO and presents them to the execute stage over a second valid/ready handshake. It replaces the purely combinational field splitter: unused fields are forced to zero instead of holding stale values, it flags illegal encodings, and it supports flush.

## Interface
- XLEN, 32, datapath width for the immediate and PC; legal values are 32 and 64.
- DEPTH, 4, queue entries; a power of two and at least 2.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discards all queued entries and any push in the same cycle.
- in_valid  in  1  instruction offered.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- instruction  in  32  raw instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  consumer takes the head entry.
- opcode  out  7  instr[6:0].
- rd, rs1, rs2  out  5 each  register indices, or 0 when the format has no such field.
- funct3  out  3  instr[14:12], or 0 for U/J formats.
- funct7  out  7  instr[31:25] for R format and for OP-IMM shifts, otherwise 0.
- imm  out  XLEN  sign-extended immediate, or 0 for R format.
- fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
- illegal  out  1  unsupported encoding.
- out_pc  out  XLEN  PC of the head entry.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Decode is combinational from instruction and in_pc. The decoded record is written into the tail entry on a push (in_valid && in_ready && !flush).
- Opcode-to-format mapping:
  - 0110011 maps to R.
  - 0010011, 0000011, 1100111 and 1110011 map to I.
  - 0100011 maps to S.
  - 1100011 maps to B.
  - 0110111 and 0010111 map to U.
  - 1101111 maps to J.
- Any other opcode, or instr[1:0] != 2'b11, sets fmt=7 and illegal=1, and zeroes rd, rs1, rs2, funct3, funct7 and imm. The entry is still enqueued so execute can trap.
- Immediate by format (sext = replicate bit 31 up to XLEN):
  - I: sext(instr[31:20]).
  - I shift (OP-IMM with funct3 = 001 or 101): {0, instr[24:20]}, and funct7 = instr[31:25].
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Field presence by format:
  - rd is present for R/I/U/J.
  - rs1 is present for R/I/S/B.
  - rs2 is present for R/S/B.
- Queue:
  - Circular buffer with write and read pointers, each $clog2(DEPTH) bits, plus count. Pointers wrap modulo DEPTH.
  - A pop is out_valid && out_ready && !flush.
  - Push and pop in the same cycle leaves count unchanged and advances both pointers. This is legal at any occupancy where in_ready=1.
  - When full, in_ready=0, so the push is ignored even if out_ready pops that cycle. Space freed by the pop is visible next cycle; there is no combinational ready-through.
- Flush: on the next edge, count, write pointer and read pointer all return to 0. A concurrent push and pop are both suppressed.

## Timing
- Reset (rst_n low, asynchronous): count=0, pointers=0, out_valid=0, in_ready=1. All head-output fields read 0 because queue storage is reset to zero.
- Latency: an instruction pushed at edge N appears on the outputs, with out_valid=1, after edge N while the queue was empty. There is no same-cycle bypass.
- Outputs are driven from registered storage only. They do not depend combinationally on instruction, in_valid or out_ready.
- Throughput: one push and one pop per cycle, sustained.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Test plan
- Reset: hold rst_n low with stimulus active. Required: count=0, out_valid=0, in_ready=1, imm=0. Then push ADDI x5,x1,-1 (0xFFF08293). Required on the next cycle: fmt=1, rd=5, rs1=1, rs2=0, imm=0xFFFFFFFF, illegal=0.
- Formats: push BEQ with offset -4 (0xFE000EE3). Required: fmt=3, imm=0xFFFFFFFC, rd=0. Push SRAI x3,x3,7 (0x4071D193). Required: imm=7, funct7=0x20. Push JAL x1,+2048 (0x001000EF). Required: fmt=5, imm=0x800.
- Backpressure: hold out_ready=0 and push 5 instructions with DEPTH=4. Required: in_ready=0 after the 4th, count=4, the 5th is not accepted, and the pop order matches the push order along with their PCs.
- Simultaneous push/pop at count=1 for 10 cycles. Required: count stays 1 and the pointers wrap without data corruption.
- Flush with count=3, asserted in the same cycle as a push and a pop. Required on the next cycle: count=0 and out_valid=0, and neither the pushed entry nor the popped entry is counted.
- Illegal and XLEN=64: push 0x0000007F. Required: fmt=7, illegal=1, all fields 0. With XLEN=64, push LUI x2,0x80000 (0x80000137). Required: imm=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/decode_queue.sv
// RV32I decode stage feeding a DEPTH-entry queue toward execute.
// Decode is combinational on the input side; all outputs come from queue storage.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instruction,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6:0]             opcode,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  output logic [XLEN-1:0]        imm,
  output logic [2:0]             fmt,
  output logic                   illegal,
  output logic [XLEN-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } rec_t;

  // Every immediate fits a signed 32-bit value; widening it sign-extends to XLEN.
  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [6:0]         opc;
  fmt_e               fmt_d;
  logic               is_shift;
  logic signed [31:0] imm32;
  rec_t               rec_d;

  // Decode stage: raw word -> record written into the tail entry
  assign opc      = instruction[6:0];
  assign is_shift = (opc == 7'b0010011) && (instruction[13:12] == 2'b01);

  always_comb begin
    fmt_d = FMT_ILL;
    if (instruction[1:0] == 2'b11) begin
      case (opc)
        7'b0110011:                                     fmt_d = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt_d = FMT_I;
        7'b0100011:                                     fmt_d = FMT_S;
        7'b1100011:                                     fmt_d = FMT_B;
        7'b0110111, 7'b0010111:                         fmt_d = FMT_U;
        7'b1101111:                                     fmt_d = FMT_J;
        default:                                        fmt_d = FMT_ILL;
      endcase
    end
  end

  always_comb begin
    rec_d         = '0;
    imm32         = '0;
    rec_d.opcode  = opc;
    rec_d.pc      = in_pc;
    rec_d.fmt     = fmt_d;
    rec_d.illegal = (fmt_d == FMT_ILL);
    case (fmt_d)
      FMT_R: begin
        rec_d.rd     = instruction[11:7];
        rec_d.rs1    = instruction[19:15];
        rec_d.rs2    = instruction[24:20];
        rec_d.funct3 = instruction[14:12];
        rec_d.funct7 = instruction[31:25];
      end
      FMT_I: begin
        rec_d.rd     = instruction[11:7];
        rec_d.rs1    = instruction[19:15];
        rec_d.funct3 = instruction[14:12];
        if (is_shift) begin
          rec_d.funct7 = instruction[31:25];
          imm32        = {27'b0, instruction[24:20]};
        end else begin
          imm32 = {{20{instruction[31]}}, instruction[31:20]};
        end
      end
      FMT_S: begin
        rec_d.rs1    = instruction[19:15];
        rec_d.rs2    = instruction[24:20];
        rec_d.funct3 = instruction[14:12];
        imm32        = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      FMT_B: begin
        rec_d.rs1    = instruction[19:15];
        rec_d.rs2    = instruction[24:20];
        rec_d.funct3 = instruction[14:12];
        imm32        = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      end
      FMT_U: begin
        rec_d.rd = instruction[11:7];
        imm32    = {instruction[31:12], 12'b0};
      end
      FMT_J: begin
        rec_d.rd = instruction[11:7];
        imm32    = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
      end
      default: ;
    endcase
    rec_d.imm = sext32(imm32);
  end

  // Queue stage: circular buffer, pointers wrap naturally at a power-of-two depth
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  rec_t             mem_q [DEPTH];
  rec_t             head;
  logic             push, pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so an empty queue presents all-zero fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= rec_d;
    end
  end

  // Output stage: head entry only, no path from the input side
  assign head    = mem_q[rptr_q];
  assign opcode  = head.opcode;
  assign rd      = head.rd;
  assign rs1     = head.rs1;
  assign rs2     = head.rs2;
  assign funct3  = head.funct3;
  assign funct7  = head.funct7;
  assign imm     = head.imm;
  assign fmt     = head.fmt;
  assign illegal = head.illegal;
  assign out_pc  = head.pc;
  assign count   = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: scoreboard of expected records, checked at the head.
module tb_decode_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instruction, in_pc, imm, out_pc;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, fmt;
  logic [2:0]  count;

  logic        v64_in, v64_flush, v64_in_ready, v64_out_valid, v64_out_ready, v64_illegal;
  logic [31:0] v64_instr;
  logic [63:0] v64_in_pc, v64_imm, v64_out_pc;
  logic [6:0]  v64_opcode, v64_funct7;
  logic [4:0]  v64_rd, v64_rs1, v64_rs2;
  logic [2:0]  v64_funct3, v64_fmt;
  logic [2:0]  v64_count;

  decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .fmt(fmt), .illegal(illegal), .out_pc(out_pc), .count(count)
  );

  decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(v64_flush), .in_valid(v64_in), .in_ready(v64_in_ready),
    .instruction(v64_instr), .in_pc(v64_in_pc), .out_valid(v64_out_valid),
    .out_ready(v64_out_ready), .opcode(v64_opcode), .rd(v64_rd), .rs1(v64_rs1),
    .rs2(v64_rs2), .funct3(v64_funct3), .funct7(v64_funct7), .imm(v64_imm), .fmt(v64_fmt),
    .illegal(v64_illegal), .out_pc(v64_out_pc), .count(v64_count)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t tbl [9];
  exp_t sb [$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(input logic [31:0] ins, input logic [6:0] op,
                              input logic [4:0] rd_e, input logic [4:0] rs1_e,
                              input logic [4:0] rs2_e, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [63:0] imm_e,
                              input logic [2:0] fmt_e, input logic ill);
    exp_t e;
    e.ins = ins; e.pc = '0; e.op = op; e.rd = rd_e; e.rs1 = rs1_e; e.rs2 = rs2_e;
    e.f3 = f3; e.f7 = f7; e.imm = imm_e; e.fmt = fmt_e; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_head(input exp_t e);
    chk("opcode",  64'(opcode),  64'(e.op));
    chk("rd",      64'(rd),      64'(e.rd));
    chk("rs1",     64'(rs1),     64'(e.rs1));
    chk("rs2",     64'(rs2),     64'(e.rs2));
    chk("funct3",  64'(funct3),  64'(e.f3));
    chk("funct7",  64'(funct7),  64'(e.f7));
    chk("imm",     64'(imm),     64'(e.imm[31:0]));
    chk("fmt",     64'(fmt),     64'(e.fmt));
    chk("illegal", 64'(illegal), 64'(e.ill));
    chk("out_pc",  64'(out_pc),  64'(e.pc[31:0]));
  endtask

  task automatic check_head64(input exp_t e);
    chk("x64.opcode",  64'(v64_opcode),  64'(e.op));
    chk("x64.rd",      64'(v64_rd),      64'(e.rd));
    chk("x64.rs1",     64'(v64_rs1),     64'(e.rs1));
    chk("x64.rs2",     64'(v64_rs2),     64'(e.rs2));
    chk("x64.funct3",  64'(v64_funct3),  64'(e.f3));
    chk("x64.funct7",  64'(v64_funct7),  64'(e.f7));
    chk("x64.imm",     v64_imm,          e.imm);
    chk("x64.fmt",     64'(v64_fmt),     64'(e.fmt));
    chk("x64.illegal", 64'(v64_illegal), 64'(e.ill));
    chk("x64.out_pc",  v64_out_pc,       e.pc);
    chk("x64.count",   64'(v64_count),   64'd1);
    chk("x64.valid",   64'(v64_out_valid), 64'd1);
    chk("x64.ready",   64'(v64_in_ready),  64'd1);
  endtask

  task automatic offer(input int idx, input logic [31:0] pc);
    in_valid    = 1'b1;
    instruction = tbl[idx].ins;
    in_pc       = pc;
    cur         = tbl[idx];
    cur.pc      = {32'b0, pc};
  endtask

  // One clock: check the head against the scoreboard, update the model, advance.
  task automatic cycle();
    bit do_push, do_pop;
    chk("count",     64'(count),     64'(sb.size()));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("in_ready",  64'(in_ready),  64'(sb.size() != DEPTH));
    if (sb.size() != 0) check_head(sb[0]);
    do_pop  = out_ready && (sb.size() != 0);
    do_push = in_valid && (sb.size() != DEPTH);
    if (flush) begin
      sb.delete();
    end else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(32'hFFF08293, 7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    tbl[1] = mk(32'hFE000EE3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
    tbl[2] = mk(32'h4071D193, 7'h13, 5'd3, 5'd3, 5'd0, 3'd5, 7'h20, 64'h7, 3'd1, 1'b0);
    tbl[3] = mk(32'h001000EF, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h800, 3'd5, 1'b0);
    tbl[4] = mk(32'h0000007F, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0, 3'd7, 1'b1);
    tbl[5] = mk(32'h002081B3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 64'h0, 3'd0, 1'b0);
    tbl[6] = mk(32'h0020A423, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 64'h8, 3'd2, 1'b0);
    tbl[7] = mk(32'h80000137, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    tbl[8] = mk(32'hFFF08290, 7'h10, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0, 3'd7, 1'b1);

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    v64_in = 1'b0; v64_flush = 1'b0; v64_out_ready = 1'b1;
    v64_instr = '0; v64_in_pc = '0;
    offer(0, 32'h100);

    // Reset held with stimulus active
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst.count",     64'(count),     64'd0);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.in_ready",  64'(in_ready),  64'd1);
      chk("rst.imm",       64'(imm),       64'd0);
    end
    rst_n = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    // Every format, one per cycle with concurrent pops
    for (int i = 1; i < 9; i++) begin
      offer(i, 32'h200 + 32'(i * 4));
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    // Backpressure: fill, offer a fifth, then pop while full with a push pending
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(i, 32'h300 + 32'(i * 4));
      cycle();
    end
    offer(5, 32'h3F0);
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();

    // Sustained push+pop at occupancy 1, pointers wrap
    out_ready = 1'b0;
    offer(6, 32'h400);
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(i % 9, 32'h500 + 32'(i * 4));
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    // Flush at count 3 with a push and a pop in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(i + 5, 32'h600 + 32'(i * 4));
      cycle();
    end
    offer(2, 32'h6F0);
    out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    cycle();
    offer(3, 32'h700);
    cycle();
    in_valid = 1'b0;
    repeat (2) cycle();

    // Asynchronous reset between edges discards entries at once
    out_ready = 1'b0;
    offer(6, 32'h800);
    cycle();
    offer(7, 32'h804);
    cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.count",     64'(count),     64'd0);
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.imm",       64'(imm),       64'd0);
    chk("arst.rd",        64'(rd),        64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();

    // XLEN=64 instance
    cur = tbl[7];
    cur.pc = 64'hFFFF_0000_0000_1000;
    v64_instr = cur.ins; v64_in_pc = cur.pc; v64_in = 1'b1;
    @(posedge clk); #1;
    check_head64(cur);
    cur = tbl[0];
    cur.pc = 64'h0000_0001_0000_0004;
    v64_instr = cur.ins; v64_in_pc = cur.pc;
    @(posedge clk); #1;
    v64_in = 1'b0;
    check_head64(cur);
    @(posedge clk); #1;
    chk("x64.drain", 64'(v64_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
